bounding_box_traverser: RTL and testbench
=========================================

# bounding_box_traverser

Consumes the clamped integer bounding box (Top, Bottom, Left, Right) produced by the bounding box generator and walks every pixel inside it in raster order. Emits one (x, y) pixel candidate per accepted handshake to the downstream edge-function/coverage stage. Accepts one box at a time over a valid/ready handshake and pulses a done flag when the box has been fully walked.

## Interface
- `COORD_W`, 32: width of all coordinate ports; matches the generator's 32-bit outputs.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bb_valid`  in  1  box fields valid.
- `bb_ready`  out  1  traverser can accept a box.
- `Top`  in  COORD_W  first row, inclusive, unsigned.
- `Bottom`  in  COORD_W  row bound, exclusive; may equal resy.
- `Left`  in  COORD_W  first column, inclusive.
- `Right`  in  COORD_W  column bound, exclusive; may equal resx.
- `px_valid`  out  1  pixel coordinate valid.
- `px_ready`  in  1  downstream accepts pixel.
- `px_x`  out  COORD_W  pixel column.
- `px_y`  out  COORD_W  pixel row.
- `px_last`  out  1  current pixel is the last one of the box.
- `box_done`  out  1  one-cycle pulse: box finished, or empty box discarded.

## Operation
- Box is half-open: columns Left..Right-1, rows Top..Bottom-1. Raster order: x fastest, then y.
- States: IDLE, SCAN.
  - IDLE: `bb_ready`=1, `px_valid`=0. On `bb_valid & bb_ready`, latch all four fields. If Left>=Right or Top>=Bottom, the box is empty: stay in IDLE, pulse `box_done` next cycle, emit no pixels. Otherwise load x=Left, y=Top and go to SCAN.
  - SCAN: `bb_ready`=0, `px_valid`=1, `px_x`/`px_y` = counters, `px_last` = (x==R-1 && y==B-1). On `px_valid & px_ready`:
    - If not at end of row: x+1.
    - If at end of row but not at the last row: x=L, y+1.
    - If at the last pixel: go to IDLE and pulse `box_done` next cycle.
- Without `px_ready`, outputs hold stable; coordinates never change while `px_valid` is high and unaccepted.
- Inputs `Top/Bottom/Left/Right` are ignored outside the accept cycle; changes during SCAN have no effect.
- Arithmetic: unsigned COORD_W compare/increment. Upstream clamps bounds to at most resx/resy, so R-1 and B-1 are computed only when R>L and B>T. No wrap is possible.
- Reset: state=IDLE, counters and latched box cleared. Reset mid-SCAN abandons the box with no `box_done` and no further pixels.

## Timing
- Reset values: `bb_ready`=1 (IDLE), `px_valid`=0, `px_x`=0, `px_y`=0, `px_last`=0, `box_done`=0.
- Box accepted at edge N: first pixel valid in cycle N+1, presented from registers.
- With `px_ready` held at 1, throughput is one pixel per cycle. A W×H box occupies SCAN for W·H cycles.
- Last pixel accepted at edge M: `box_done`=1 and `bb_ready`=1 in cycle M+1, so there is one IDLE cycle between back-to-back boxes.
- Empty box accepted at edge N: `box_done`=1 in cycle N+1, and `bb_ready` stays 1.
- `box_done` is registered and lasts exactly one cycle.

## Structure
- Shared package `traverser_pkg`: `COORD_W` default and the state encoding (IDLE, SCAN), reused by the downstream coverage stage.
- One natural sub-module, `bb_axis_counter`: a loadable COORD_W counter with an inclusive-end compare that outputs `at_end`. Instantiate it twice:
  - x instance: load on accept or row wrap.
  - y instance: increments on row wrap.
- The top level holds the FSM, the box latch, `px_last` and `box_done`.

## Test plan
- Small box: T=1, B=3, L=4, R=6, `px_ready`=1.
  - Required pixels: (4,1), (5,1), (4,2), (5,2).
  - `px_last` only on (5,2); `box_done` one cycle later.
- Generator-sized box: T=1, B=19, L=4, R=13.
  - Exactly 162 pixels, first (4,1), last (12,18).
  - `px_valid` continuous for 162 cycles.
- Screen-edge box: T=1079, B=1080, L=1918, R=1920.
  - Pixels (1918,1079) and (1919,1079) only; no x=1920 emitted.
- Backpressure: T=0, B=2, L=0, R=2, with `px_ready` toggling 1,0,0,1,0,1,1.
  - Each coordinate held stable until accepted.
  - Order (0,0), (1,0), (0,1), (1,1).
- Empty boxes: L=R=7, then separately T=B=5.
  - No `px_valid`; `box_done` pulses next cycle; `bb_ready` remains 1.
- Reset mid-SCAN: assert `rst` after the 3rd pixel of the T=1, B=19, L=4, R=13 box.
  - Next cycle: `px_valid`=0, `bb_ready`=1, no `box_done`.
  - A new box then starts from its own (Left, Top).

Source files
------------

// File: rtl/traverser_pkg.sv
// rtl/traverser_pkg.sv - shared coordinate width and traversal state encoding
package traverser_pkg;

  localparam int unsigned COORD_W_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } trav_state_e;

endpackage

// File: rtl/bounding_box_traverser_if.sv
// rtl/bounding_box_traverser_if.sv - box input and pixel output handshakes of the traverser
interface bounding_box_traverser_if #(
  parameter int unsigned COORD_W = traverser_pkg::COORD_W_DEF
);

  logic               bb_valid;
  logic               bb_ready;
  logic [COORD_W-1:0] Top;
  logic [COORD_W-1:0] Bottom;
  logic [COORD_W-1:0] Left;
  logic [COORD_W-1:0] Right;

  logic               px_valid;
  logic               px_ready;
  logic [COORD_W-1:0] px_x;
  logic [COORD_W-1:0] px_y;
  logic               px_last;
  logic               box_done;

  modport master (
    output bb_valid, Top, Bottom, Left, Right, px_ready,
    input  bb_ready, px_valid, px_x, px_y, px_last, box_done
  );

  modport slave (
    input  bb_valid, Top, Bottom, Left, Right, px_ready,
    output bb_ready, px_valid, px_x, px_y, px_last, box_done
  );

endinterface

// File: rtl/bounding_box_traverser_bb_axis_counter.sv
// rtl/bounding_box_traverser_bb_axis_counter.sv - loadable coordinate counter with inclusive end compare
module bb_axis_counter
  import traverser_pkg::*;
#(
  parameter int unsigned W = COORD_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] end_val_i,
  output logic [W-1:0] cnt_o,
  output logic         at_end_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over increment so a row wrap can restart at the left column.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_end_o = (cnt_q == end_val_i);

endmodule

// File: rtl/bounding_box_traverser.sv
// rtl/bounding_box_traverser.sv - walks every pixel of a half-open box in raster order
module bounding_box_traverser
  import traverser_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input logic                     clk,
  input logic                     rst,
  bounding_box_traverser_if.slave bb_if
);

  trav_state_e state_q;
  trav_state_e state_d;

  logic [COORD_W-1:0] top_q, top_d;
  logic [COORD_W-1:0] bottom_q, bottom_d;
  logic [COORD_W-1:0] left_q, left_d;
  logic [COORD_W-1:0] right_q, right_d;
  logic               box_done_q, box_done_d;

  logic               x_load;
  logic [COORD_W-1:0] x_load_val;
  logic               x_inc;
  logic               y_load;
  logic               y_inc;
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic               x_at_end;
  logic               y_at_end;
  logic [COORD_W-1:0] x_end;
  logic [COORD_W-1:0] y_end;
  logic               box_empty;
  logic               bb_ready;
  logic               px_valid;

  assign box_empty = (bb_if.Left >= bb_if.Right) || (bb_if.Top >= bb_if.Bottom);

  // Inclusive end points; the guard keeps an empty latched box from underflowing.
  assign x_end = (right_q > left_q) ? right_q - COORD_W'(1) : left_q;
  assign y_end = (bottom_q > top_q) ? bottom_q - COORD_W'(1) : top_q;

  bb_axis_counter #(.W(COORD_W)) u_x_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (x_load),
    .load_val_i (x_load_val),
    .inc_i      (x_inc),
    .end_val_i  (x_end),
    .cnt_o      (x_cnt),
    .at_end_o   (x_at_end)
  );

  bb_axis_counter #(.W(COORD_W)) u_y_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (y_load),
    .load_val_i (bb_if.Top),
    .inc_i      (y_inc),
    .end_val_i  (y_end),
    .cnt_o      (y_cnt),
    .at_end_o   (y_at_end)
  );

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    bottom_d   = bottom_q;
    left_d     = left_q;
    right_d    = right_q;
    box_done_d = 1'b0;
    x_load     = 1'b0;
    x_load_val = left_q;
    x_inc      = 1'b0;
    y_load     = 1'b0;
    y_inc      = 1'b0;
    bb_ready   = 1'b0;
    px_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bb_ready = 1'b1;
        if (bb_if.bb_valid) begin
          top_d    = bb_if.Top;
          bottom_d = bb_if.Bottom;
          left_d   = bb_if.Left;
          right_d  = bb_if.Right;
          if (box_empty) begin
            box_done_d = 1'b1;
          end else begin
            x_load     = 1'b1;
            x_load_val = bb_if.Left;
            y_load     = 1'b1;
            state_d    = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        px_valid = 1'b1;
        if (bb_if.px_ready) begin
          if (!x_at_end) begin
            x_inc = 1'b1;
          end else if (!y_at_end) begin
            x_load = 1'b1;
            y_inc  = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            box_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      top_q      <= '0;
      bottom_q   <= '0;
      left_q     <= '0;
      right_q    <= '0;
      box_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      bottom_q   <= bottom_d;
      left_q     <= left_d;
      right_q    <= right_d;
      box_done_q <= box_done_d;
    end
  end

  assign bb_if.bb_ready = bb_ready;
  assign bb_if.px_valid = px_valid;
  assign bb_if.px_x     = x_cnt;
  assign bb_if.px_y     = y_cnt;
  assign bb_if.px_last  = (state_q == ST_SCAN) && x_at_end && y_at_end;
  assign bb_if.box_done = box_done_q;

endmodule

// File: tb/tb_bounding_box_traverser.sv
// tb/tb_bounding_box_traverser.sv - self-checking bench for bounding_box_traverser
module tb_bounding_box_traverser;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  pix_t exp_q[$];
  pix_t cap[$];
  logic cap_last[$];
  bit   exp_done = 1'b0;
  int   done_cnt = 0;
  int   run_len  = 0;
  int   max_run  = 0;

  bounding_box_traverser_if #(.COORD_W(32)) bif ();

  bounding_box_traverser #(.COORD_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bb_if (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: a queue holding every pixel the current box still owes.
  always @(negedge clk) begin
    bit   nxt_done;
    pix_t p;
    chk("bb_ready", {63'd0, bif.bb_ready}, {63'd0, exp_q.size() == 0});
    chk("px_valid", {63'd0, bif.px_valid}, {63'd0, exp_q.size() != 0});
    chk("box_done", {63'd0, bif.box_done}, {63'd0, exp_done});
    if (bif.box_done) done_cnt++;
    if (exp_q.size() != 0) begin
      chk("px_x", {32'd0, bif.px_x}, {32'd0, exp_q[0].x});
      chk("px_y", {32'd0, bif.px_y}, {32'd0, exp_q[0].y});
      chk("px_last", {63'd0, bif.px_last}, {63'd0, exp_q.size() == 1});
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end

    nxt_done = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (bif.px_ready) begin
        cap.push_back({bif.px_x, bif.px_y});
        cap_last.push_back(bif.px_last);
        if (exp_q.size() == 1) nxt_done = 1'b1;
        void'(exp_q.pop_front());
      end
    end else if (bif.bb_valid) begin
      if (bif.Left >= bif.Right || bif.Top >= bif.Bottom) begin
        nxt_done = 1'b1;
      end else begin
        for (longint y = bif.Top; y < bif.Bottom; y++) begin
          for (longint x = bif.Left; x < bif.Right; x++) begin
            p.x = x[31:0];
            p.y = y[31:0];
            exp_q.push_back(p);
          end
        end
      end
    end
    exp_done = nxt_done;
  end

  task automatic send_box(input logic [31:0] t, input logic [31:0] b,
                          input logic [31:0] l, input logic [31:0] r);
    bit ok;
    ok = 1'b0;
    bif.Top = t; bif.Bottom = b; bif.Left = l; bif.Right = r;
    bif.bb_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = bif.bb_ready;
      @(posedge clk);
      #1;
    end
    bif.bb_valid = 1'b0;
    bif.Top = $urandom; bif.Bottom = $urandom; bif.Left = $urandom; bif.Right = $urandom;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int start, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = (done_cnt != start);
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic new_box();
    cap.delete();
    cap_last.delete();
    max_run = 0;
  endtask

  int   start;
  int   lasts;
  logic pat[7];

  initial begin
    bif.bb_valid = 1'b0;
    bif.px_ready = 1'b1;
    bif.Top = '0; bif.Bottom = '0; bif.Left = '0; bif.Right = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_bb_ready", {63'd0, bif.bb_ready}, 64'd1);
    chk("rst_px_valid", {63'd0, bif.px_valid}, 64'd0);
    chk("rst_px_x", {32'd0, bif.px_x}, 64'd0);
    chk("rst_px_y", {32'd0, bif.px_y}, 64'd0);
    chk("rst_px_last", {63'd0, bif.px_last}, 64'd0);
    chk("rst_box_done", {63'd0, bif.box_done}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // small box
    new_box(); start = done_cnt;
    send_box(32'd1, 32'd3, 32'd4, 32'd6);
    wait_done(start, 50);
    chk("small_count", 64'(cap.size()), 64'd4);
    if (cap.size() == 4) begin
      chk("small_p0", cap[0], {32'd4, 32'd1});
      chk("small_p1", cap[1], {32'd5, 32'd1});
      chk("small_p2", cap[2], {32'd4, 32'd2});
      chk("small_p3", cap[3], {32'd5, 32'd2});
      lasts = 0;
      foreach (cap_last[i]) if (cap_last[i]) lasts++;
      chk("small_last_count", 64'(lasts), 64'd1);
      chk("small_last_pos", {63'd0, cap_last[3]}, 64'd1);
    end

    // generator-sized box, back to back
    new_box(); start = done_cnt;
    send_box(32'd1, 32'd19, 32'd4, 32'd13);
    wait_done(start, 400);
    chk("gen_count", 64'(cap.size()), 64'd162);
    chk("gen_run", 64'(max_run), 64'd162);
    if (cap.size() == 162) begin
      chk("gen_first", cap[0], {32'd4, 32'd1});
      chk("gen_last", cap[161], {32'd12, 32'd18});
    end

    // screen edge
    new_box(); start = done_cnt;
    send_box(32'd1079, 32'd1080, 32'd1918, 32'd1920);
    wait_done(start, 50);
    chk("edge_count", 64'(cap.size()), 64'd2);
    if (cap.size() == 2) begin
      chk("edge_p0", cap[0], {32'd1918, 32'd1079});
      chk("edge_p1", cap[1], {32'd1919, 32'd1079});
    end

    // backpressure
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    new_box(); start = done_cnt;
    send_box(32'd0, 32'd2, 32'd0, 32'd2);
    for (int i = 0; i < 7; i++) begin
      bif.px_ready = pat[i];
      @(posedge clk);
      #1;
    end
    bif.px_ready = 1'b1;
    wait_done(start, 50);
    chk("bp_count", 64'(cap.size()), 64'd4);
    if (cap.size() == 4) begin
      chk("bp_p0", cap[0], {32'd0, 32'd0});
      chk("bp_p1", cap[1], {32'd1, 32'd0});
      chk("bp_p2", cap[2], {32'd0, 32'd1});
      chk("bp_p3", cap[3], {32'd1, 32'd1});
    end

    // empty boxes
    new_box();
    send_box(32'd1, 32'd3, 32'd7, 32'd7);
    @(negedge clk);
    chk("emptyx_done", {63'd0, bif.box_done}, 64'd1);
    chk("emptyx_ready", {63'd0, bif.bb_ready}, 64'd1);
    chk("emptyx_valid", {63'd0, bif.px_valid}, 64'd0);
    @(posedge clk);
    #1;
    send_box(32'd5, 32'd5, 32'd0, 32'd4);
    @(negedge clk);
    chk("emptyy_done", {63'd0, bif.box_done}, 64'd1);
    chk("emptyy_ready", {63'd0, bif.bb_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("empty_pixels", 64'(cap.size()), 64'd0);

    // reset mid-scan
    new_box();
    send_box(32'd1, 32'd19, 32'd4, 32'd13);
    for (int i = 0; i < 20 && cap.size() < 3; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstscan_valid", {63'd0, bif.px_valid}, 64'd0);
    chk("rstscan_ready", {63'd0, bif.bb_ready}, 64'd1);
    chk("rstscan_done", {63'd0, bif.box_done}, 64'd0);
    chk("rstscan_count", 64'(cap.size()), 64'd3);
    @(posedge clk);
    #1;
    new_box(); start = done_cnt;
    send_box(32'd2, 32'd3, 32'd10, 32'd12);
    wait_done(start, 50);
    chk("after_rst_count", 64'(cap.size()), 64'd2);
    if (cap.size() == 2) chk("after_rst_first", cap[0], {32'd10, 32'd2});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
